// File: rtl/hypb_cordic_if.sv
// hypb_cordic_if
// Handshake bundle between the hyperbolic CORDIC iteration sequencer and its
// environment (control block on one side, atanh LUT + shift/add datapath on
// the other).
//
// Signals:
//   start_i       request a new iteration sequence
//   expand_i      1 = include the expanded-range (negative) indices
//   abort_i       cancel the running sequence
//   step_ready_i  datapath accepts the current step
//   busy_o        sequencer is not idle
//   step_valid_o  index_o / repeat_o / last_o are valid
//   index_o       signed iteration index (LUT index and shift amount)
//   repeat_o      current step is the second issue of a repeated index
//   last_o        current step is the final one
//   step_cnt_o    number of steps already accepted
//   done_o        one-cycle pulse after the final step is accepted
//
// Modports:
//   master  the sequencer itself
//   slave   the environment driving requests and consuming steps
interface hypb_cordic_if;
    logic              start_i;
    logic              expand_i;
    logic              abort_i;
    logic              step_ready_i;
    logic              busy_o;
    logic              step_valid_o;
    logic signed [7:0] index_o;
    logic              repeat_o;
    logic              last_o;
    logic [4:0]        step_cnt_o;
    logic              done_o;

    modport master (
        input  start_i, expand_i, abort_i, step_ready_i,
        output busy_o, step_valid_o, index_o, repeat_o, last_o, step_cnt_o, done_o
    );

    modport slave (
        output start_i, expand_i, abort_i, step_ready_i,
        input  busy_o, step_valid_o, index_o, repeat_o, last_o, step_cnt_o, done_o
    );
endinterface

// File: rtl/hypb_cordic_seq.sv
// hypb_cordic_seq
// Iteration sequencer for the hyperbolic-mode CORDIC. Walks the index
// schedule NEG_MIN..0 (optional) then 1..POS_MAX, issuing REP_A and REP_B
// twice, and presents one index per accepted valid/ready handshake. It holds
// no arithmetic; the atanh LUT and shift/add datapath hang off index_o.
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    hypb_cordic_if.master (start/expand/abort in, step handshake out)
//
// Parameters:
//   NEG_MIN  lowest expanded-range index (-5..0)
//   POS_MAX  last positive index (1..13)
//   REP_A    first repeated index (ignored if > POS_MAX)
//   REP_B    second repeated index (ignored if > POS_MAX or == REP_A)
module hypb_cordic_seq #(
    parameter int NEG_MIN = -5,
    parameter int POS_MAX = 13,
    parameter int REP_A   = 4,
    parameter int REP_B   = 13
) (
    input  logic           clk,
    input  logic           rst_n,
    hypb_cordic_if.master  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic signed [7:0] NEG_IDX  = 8'(NEG_MIN);
    localparam logic signed [7:0] POS_IDX  = 8'(POS_MAX);
    localparam logic signed [7:0] REPA_IDX = 8'(REP_A);
    localparam logic signed [7:0] REPB_IDX = 8'(REP_B);
    localparam bit REPA_EN = (REP_A <= POS_MAX);
    localparam bit REPB_EN = (REP_B <= POS_MAX) && (REP_B != REP_A);

    state_t            state_q, state_d;
    logic signed [7:0] index_q, index_d;
    logic              rep_q, rep_d;
    logic              last_q, last_d;
    logic              valid_q, valid_d;
    logic              done_q, done_d;
    logic              busy_q, busy_d;
    logic [4:0]        cnt_q, cnt_d;

    // An index is issued twice when it matches an enabled repeat slot.
    function automatic logic is_rep(input logic signed [7:0] idx);
        return (REPA_EN && (idx == REPA_IDX)) || (REPB_EN && (idx == REPB_IDX));
    endfunction

    // The final step is POS_MAX, on its second issue if POS_MAX repeats.
    function automatic logic is_last(input logic signed [7:0] idx, input logic rep);
        return (idx == POS_IDX) && (rep || !is_rep(idx));
    endfunction

    // Next-state and next-output logic. Every output is registered, so this
    // block computes the values the outputs take after the coming edge.
    // Abort takes priority over a handshake in the same cycle.
    always_comb begin
        state_d = state_q;
        index_d = index_q;
        rep_d   = rep_q;
        last_d  = last_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.start_i && !bus.abort_i) begin
                    state_d = RUN;
                    index_d = bus.expand_i ? NEG_IDX : 8'sd1;
                    rep_d   = 1'b0;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    last_d  = is_last(index_d, 1'b0);
                end
            end
            RUN: begin
                if (bus.abort_i) begin
                    state_d = IDLE;
                    index_d = '0;
                    cnt_d   = '0;
                    rep_d   = 1'b0;
                    last_d  = 1'b0;
                    valid_d = 1'b0;
                end else if (valid_q && bus.step_ready_i) begin
                    cnt_d = cnt_q + 5'd1;
                    if (last_q) begin
                        state_d = DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        rep_d   = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        if (is_rep(index_q) && !rep_q) begin
                            rep_d = 1'b1;
                        end else begin
                            index_d = index_q + 8'sd1;
                            rep_d   = 1'b0;
                        end
                        last_d = is_last(index_d, rep_d);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (bus.abort_i) begin
                    index_d = '0;
                    cnt_d   = '0;
                end
            end
            default: begin
                state_d = IDLE;
                index_d = '0;
                cnt_d   = '0;
                rep_d   = 1'b0;
                last_d  = 1'b0;
                valid_d = 1'b0;
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset clears everything immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            index_q <= '0;
            rep_q   <= 1'b0;
            last_q  <= 1'b0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            busy_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            index_q <= index_d;
            rep_q   <= rep_d;
            last_q  <= last_d;
            valid_q <= valid_d;
            done_q  <= done_d;
            busy_q  <= busy_d;
            cnt_q   <= cnt_d;
        end
    end

    assign bus.busy_o       = busy_q;
    assign bus.step_valid_o = valid_q;
    assign bus.index_o      = index_q;
    assign bus.repeat_o     = rep_q;
    assign bus.last_o       = last_q;
    assign bus.step_cnt_o   = cnt_q;
    assign bus.done_o       = done_q;

endmodule

// File: tb/tb_hypb_cordic_seq.sv
// tb_hypb_cordic_seq
// Directed self-checking bench for hypb_cordic_seq with default parameters.
// Expected schedules are hand-written tables; each scenario task drives its
// stimulus and compares outputs inline, sampling 1 ns after the rising edge.
module tb_hypb_cordic_seq;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    hypb_cordic_if sif ();

    hypb_cordic_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sif.master)
    );

    // Full default schedule with expansion; the non-expanded run starts at entry 6.
    int exp_idx [21] = '{-5, -4, -3, -2, -1, 0, 1, 2, 3, 4, 4,
                         5, 6, 7, 8, 9, 10, 11, 12, 13, 13};
    bit exp_rep [21] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1,
                         0, 0, 0, 0, 0, 0, 0, 0, 0, 1};

    // 100 MHz free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one sequence from IDLE and checks every step against the table.
    // stall_pct > 0 randomly drops ready; abort_at >= 0 aborts on that step;
    // pulse_start raises start_i mid-run and in the DONE cycle.
    task automatic run_sequence(input bit expand, input int stall_pct,
                                input int abort_at, input bit pulse_start);
        int len, off, k, cyc, guard;
        bit rdy, er, el;
        logic signed [7:0] ei;
        len = expand ? 21 : 15;
        off = expand ? 0 : 6;
        k = 0; cyc = 0; guard = 0;
        sif.expand_i = expand;
        sif.start_i  = 1'b1;
        @(posedge clk); #1;
        sif.start_i  = 1'b0;
        sif.expand_i = 1'b0;
        cyc = 1;
        while (k < len && guard < 600) begin
            guard++;
            rdy = (stall_pct == 0) ? 1'b1 : ($urandom_range(0, 99) >= stall_pct);
            sif.step_ready_i = rdy;
            sif.start_i = pulse_start && (k == 3);
            ei = 8'(exp_idx[off + k]);
            er = exp_rep[off + k];
            el = (k == len - 1);
            checks++;
            if ({sif.busy_o, sif.step_valid_o, sif.index_o, sif.repeat_o, sif.last_o,
                 sif.step_cnt_o, sif.done_o} !== {1'b1, 1'b1, ei, er, el, 5'(k), 1'b0}) begin
                failures++;
                $display("[TB] FAIL step%0d: got busy=%0b v=%0b idx=%0d rep=%0b last=%0b cnt=%0d done=%0b, want idx=%0d rep=%0b last=%0b cnt=%0d",
                         k, sif.busy_o, sif.step_valid_o, sif.index_o, sif.repeat_o, sif.last_o,
                         sif.step_cnt_o, sif.done_o, ei, er, el, k);
            end
            if (abort_at == k) begin
                sif.step_ready_i = 1'b1;
                sif.abort_i = 1'b1;
                @(posedge clk); #1;
                sif.abort_i = 1'b0;
                checks++;
                if ({sif.busy_o, sif.step_valid_o, sif.index_o, sif.repeat_o, sif.last_o,
                     sif.step_cnt_o, sif.done_o} !== 17'd0) begin
                    failures++;
                    $display("[TB] FAIL abort_clear: got busy=%0b v=%0b idx=%0d rep=%0b last=%0b cnt=%0d done=%0b, want all 0",
                             sif.busy_o, sif.step_valid_o, sif.index_o, sif.repeat_o, sif.last_o,
                             sif.step_cnt_o, sif.done_o);
                end
                repeat (4) begin
                    @(posedge clk); #1;
                    checks++;
                    if (sif.done_o !== 1'b0 || sif.busy_o !== 1'b0) begin
                        failures++;
                        $display("[TB] FAIL abort_no_done: got done=%0b busy=%0b, want 0 0",
                                 sif.done_o, sif.busy_o);
                    end
                end
                return;
            end
            if (rdy) k++;
            @(posedge clk); #1;
            cyc++;
        end
        sif.start_i = pulse_start;
        checks++;
        if (k < len) begin
            failures++;
            $display("[TB] FAIL seq_timeout: got %0d steps, want %0d", k, len);
        end
        checks++;
        if ({sif.done_o, sif.step_valid_o, sif.last_o, sif.repeat_o, sif.busy_o, sif.step_cnt_o}
            !== {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'(len)}) begin
            failures++;
            $display("[TB] FAIL done_cycle: got done=%0b v=%0b last=%0b rep=%0b busy=%0b cnt=%0d, want 1 0 0 0 1 %0d",
                     sif.done_o, sif.step_valid_o, sif.last_o, sif.repeat_o, sif.busy_o,
                     sif.step_cnt_o, len);
        end
        if (stall_pct == 0) begin
            checks++;
            if (cyc != len + 1) begin
                failures++;
                $display("[TB] FAIL done_latency: got cycle %0d, want %0d", cyc, len + 1);
            end
        end
        @(posedge clk); #1;
        sif.start_i = 1'b0;
        repeat (3) begin
            checks++;
            if (sif.busy_o !== 1'b0 || sif.done_o !== 1'b0 || sif.step_valid_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL post_done_idle: got busy=%0b done=%0b v=%0b, want 0 0 0",
                         sif.busy_o, sif.done_o, sif.step_valid_o);
            end
            @(posedge clk); #1;
        end
    endtask

    // Outputs are all zero while reset is held and after its release.
    task automatic test_reset();
        rst_n = 1'b0;
        sif.start_i = 1'b0; sif.expand_i = 1'b0; sif.abort_i = 1'b0; sif.step_ready_i = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if ({sif.busy_o, sif.step_valid_o, sif.index_o, sif.repeat_o, sif.last_o,
             sif.step_cnt_o, sif.done_o} !== 17'd0) begin
            failures++;
            $display("[TB] FAIL reset_state: got busy=%0b v=%0b idx=%0d cnt=%0d done=%0b, want all 0",
                     sif.busy_o, sif.step_valid_o, sif.index_o, sif.step_cnt_o, sif.done_o);
        end
        rst_n = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (sif.busy_o !== 1'b0 || sif.step_valid_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL reset_release: got busy=%0b v=%0b, want 0 0",
                     sif.busy_o, sif.step_valid_o);
        end
    endtask

    task automatic test_normal();
        $display("[TB] sequence without expansion");
        run_sequence(1'b0, 0, -1, 1'b0);
    endtask

    task automatic test_expanded();
        $display("[TB] sequence with expansion");
        run_sequence(1'b1, 0, -1, 1'b0);
    endtask

    task automatic test_backpressure();
        $display("[TB] random backpressure");
        run_sequence(1'b1, 40, -1, 1'b0);
        run_sequence(1'b0, 60, -1, 1'b0);
    endtask

    task automatic test_abort();
        $display("[TB] abort on step 7 then full run");
        run_sequence(1'b0, 0, 7, 1'b0);
        run_sequence(1'b0, 0, -1, 1'b0);
    endtask

    task automatic test_start_ignored();
        $display("[TB] start pulses while busy and in DONE");
        run_sequence(1'b1, 0, -1, 1'b1);
    endtask

    // Abort held in IDLE must block a simultaneous start.
    task automatic test_abort_blocks_start();
        sif.start_i = 1'b1;
        sif.abort_i = 1'b1;
        @(posedge clk); #1;
        sif.start_i = 1'b0;
        sif.abort_i = 1'b0;
        checks++;
        if (sif.busy_o !== 1'b0 || sif.step_valid_o !== 1'b0) begin
            failures++;
            $display("[TB] FAIL abort_blocks_start: got busy=%0b v=%0b, want 0 0",
                     sif.busy_o, sif.step_valid_o);
        end
    endtask

    // Reset asserted between edges mid-run clears outputs without a clock.
    task automatic test_async_reset();
        sif.step_ready_i = 1'b1;
        sif.start_i = 1'b1;
        @(posedge clk); #1;
        sif.start_i = 1'b0;
        repeat (5) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({sif.busy_o, sif.step_valid_o, sif.index_o, sif.repeat_o, sif.last_o,
             sif.step_cnt_o, sif.done_o} !== 17'd0) begin
            failures++;
            $display("[TB] FAIL async_reset: got busy=%0b v=%0b idx=%0d cnt=%0d done=%0b, want all 0",
                     sif.busy_o, sif.step_valid_o, sif.index_o, sif.step_cnt_o, sif.done_o);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (2) begin
            @(posedge clk); #1;
            checks++;
            if (sif.done_o !== 1'b0 || sif.busy_o !== 1'b0) begin
                failures++;
                $display("[TB] FAIL reset_no_done: got done=%0b busy=%0b, want 0 0",
                         sif.done_o, sif.busy_o);
            end
        end
        run_sequence(1'b1, 0, -1, 1'b0);
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_normal();
        test_expanded();
        test_backpressure();
        test_abort();
        test_start_ignored();
        test_abort_blocks_start();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/hypb_cordic_seq.md
# hypb_cordic_seq

Iteration sequencer for the hyperbolic-mode CORDIC used by the Softmax vector engine. On a start request it walks the hyperbolic iteration schedule, including the optional expanded-range (negative-index) iterations and the mandatory repeated iterations. Each step it presents one signed index to the atanh lookup and the shift/add datapath under a valid/ready handshake, then signals completion. It owns no arithmetic; it only sequences the existing LUT and datapath.

## Interface
- NEG_MIN, -5: lowest expanded-range index; legal range -5..0.
- POS_MAX, 13: last positive index; legal range 1..13.
- REP_A, 4: first repeated index; ignored if > POS_MAX.
- REP_B, 13: second repeated index; ignored if > POS_MAX or equal to REP_A.
- clk  in  1  single clock; all state changes on its rising edge.
- rst_n  in  1  reset, asynchronous and active-low.
- start_i  in  1  begin a sequence; sampled only in IDLE.
- expand_i  in  1  sampled with start_i; 1 = run indices NEG_MIN..0 before the positive indices.
- abort_i  in  1  cancel the current sequence.
- step_ready_i  in  1  datapath accepts the current step.
- busy_o  out  1  state != IDLE.
- step_valid_o  out  1  index_o/repeat_o/last_o are valid.
- index_o  out  8  signed iteration index; drives the atanh LUT index and the datapath shift amount.
- repeat_o  out  1  current step is the second issue of a repeated index.
- last_o  out  1  current step is the final step of the sequence.
- step_cnt_o  out  5  zero-based count of steps already accepted.
- done_o  out  1  one-cycle pulse after the final step is accepted.

## Operation
- States: IDLE, RUN, DONE. All outputs are registered.
- Reset: state IDLE; all outputs 0, including index_o = 0 and step_cnt_o = 0.
- IDLE -> RUN when start_i=1 and abort_i=0.
  - expand_i is latched at this point.
  - index_o is loaded with NEG_MIN if expand_i=1, else 1.
  - step_valid_o rises.
- In RUN, a step is accepted in any cycle with step_valid_o & step_ready_i. On acceptance:
  - step_cnt_o increments.
  - If the accepted index equals REP_A or REP_B and repeat_o=0, the next step keeps the same index with repeat_o=1.
  - Otherwise index_o increments and repeat_o clears.
- Schedule with defaults, expand=1: -5,-4,-3,-2,-1,0,1,2,3,4,4r,5,...,12,13,13r. That is 21 steps.
- Schedule with defaults, expand=0: 1..4,4r,5..13,13r. That is 15 steps.
- last_o is 1 exactly on the final step: index POS_MAX, with repeat_o=1 if POS_MAX is a repeated index.
- Acceptance of the last_o step -> DONE. In DONE, step_valid_o, last_o and repeat_o are 0 and done_o=1 for that cycle.
- DONE -> IDLE unconditionally after one cycle. start_i is ignored while in DONE.
- Stall: while step_ready_i=0, index_o, repeat_o, last_o and step_cnt_o hold; step_valid_o stays 1.
- Abort: abort_i=1 in RUN or DONE -> IDLE next cycle.
  - step_valid_o, repeat_o, last_o and done_o go to 0; index_o and step_cnt_o reset to 0.
  - No done_o pulse occurs.
  - Abort wins over a simultaneous handshake.
  - In IDLE, abort_i has no effect and blocks a simultaneous start_i.
- start_i while busy is ignored; it is not queued.
- index_o never leaves NEG_MIN..POS_MAX while step_valid_o=1.

## Timing
- start_i sampled at edge N -> step_valid_o=1, busy_o=1 from cycle N+1.
- With step_ready_i tied high: one step per cycle; a K-step sequence occupies cycles N+1..N+K; done_o in cycle N+K+1; busy_o low from N+K+2.
- A new start_i is accepted in cycle N+K+2 at the earliest.
- Handshake latency: a step accepted at edge M -> next index visible in cycle M+1. There are no bubbles between accepted steps.
- The LUT is combinational off index_o, so the datapath sees the atanh value in the same cycle as step_valid_o.
- Asynchronous reset mid-sequence forces the reset values immediately; no done_o follows.

## Test plan
- Reset, then start_i=1, expand_i=0, ready=1:
  - indices 1,2,3,4,4,5..13,13, with repeat_o=1 only on the second 4 and the second 13.
  - last_o on step 15; done_o one cycle later; step_cnt_o reaches 15.
- start_i=1, expand_i=1, ready=1:
  - first index -5 (0xFB), then -4..0; 21 steps total.
  - done_o in cycle N+22.
- Random step_ready_i backpressure: outputs stable during every stall; schedule and step count are identical to the no-stall run.
- abort_i asserted on step 7:
  - IDLE next cycle; all outputs 0; no done_o.
  - A following start_i runs a full, correct sequence.
- start_i pulsed while busy and in DONE: ignored; exactly one done_o.
- rst_n low mid-RUN: outputs 0 immediately and asynchronously; the next start_i gives a correct sequence.
